// File: rtl/fetch_queue.sv
// Fetch stage: drives icache reads at fetch_pc and queues {instr, pc+WBYTES} for decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned WBYTES  = 4,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] fetch_pc,
  output logic              pc_adv,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_pc_plus,
  output logic              halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic {StRun, StHalted} state_e;

  state_e            state_q;
  ptr_t              rd_ptr_q;
  ptr_t              wr_ptr_q;
  cnt_t              count_q;
  logic [WORD_W-1:0] instr_mem [DEPTH];
  logic [WORD_W-1:0] pcp_mem   [DEPTH];

  logic              stored_valid;
  logic              has_space;
  logic              push;
  logic              pop;
  logic              bypass;
  logic              wr_en;
  logic              rd_en;
  logic              halt_fetch;
  logic [WORD_W-1:0] pc_plus_new;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign stored_valid = (count_q != '0);
  // A full queue that is popped this cycle still frees a slot for the incoming word.
  assign has_space    = (count_q < CntW'(DEPTH)) | (id_ready & stored_valid);
  assign imemREN      = ~RST & (state_q == StRun) & ~flush & has_space;
  assign imemaddr     = fetch_pc;
  assign push         = imemREN & ihit;
  assign pc_adv       = push;
  assign pc_plus_new  = fetch_pc + WORD_W'(WBYTES);
  assign halt_fetch   = push & (imemload[WORD_W-1 -: 6] == HALT_OP);
  assign halted       = (state_q == StHalted);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push & ~stored_valid;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = stored_valid | bypass;
  assign pop      = id_valid & id_ready & ~flush;

  // A bypassed word consumed in the same cycle never touches storage.
  assign wr_en = push & ~(bypass & id_ready);
  assign rd_en = pop & ~bypass;

  always_comb begin
    id_instr   = '0;
    id_pc_plus = '0;
    if (stored_valid) begin
      id_instr   = instr_mem[rd_ptr_q];
      id_pc_plus = pcp_mem[rd_ptr_q];
    end else if (bypass) begin
      id_instr   = imemload;
      id_pc_plus = pc_plus_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      instr_mem[wr_ptr_q] <= imemload;
      pcp_mem[wr_ptr_q]   <= pc_plus_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state_q  <= StRun;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      unique case (state_q)
        StRun:    if (halt_fetch) state_q <= StHalted;
        StHalted: state_q <= StHalted;
        default:  state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized + directed bench for fetch_queue with a queue-based reference model and scoreboard.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [5:0]  HALT  = 6'b111111;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] fetch_pc;
  logic        pc_adv;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus;
  logic        halted;

  always #5 CLK = ~CLK;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .WORD_W (32),
    .WBYTES (4),
    .HALT_OP(HALT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .fetch_pc  (fetch_pc),
    .pc_adv    (pc_adv),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .flush     (flush),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc_plus(id_pc_plus),
    .halted    (halted)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp;
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  ent_t        sb[$];
  int          mcount = 0;
  bit          mhalt  = 1'b0;
  logic [31:0] cur_pc = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] non_halt();
    logic [5:0]  op;
    logic [25:0] rest;
    op   = 6'($urandom_range(0, 62));
    rest = 26'($urandom);
    return {op, rest};
  endfunction

  // One clock: drive inputs at negedge, check against the model, then advance the model.
  task automatic cycle(input logic rst, input logic [31:0] pc, input logic hit,
                       input logic [31:0] load, input logic fl, input logic rdy);
    int cnt;
    bit ren, push, byp, vld, pop;
    @(negedge CLK);
    RST = rst; fetch_pc = pc; ihit = hit; imemload = load; flush = fl; id_ready = rdy;
    #1;
    if (rst) begin
      chk("imemREN_in_reset", 32'(imemREN), 32'd0);
      chk("pc_adv_in_reset", 32'(pc_adv), 32'd0);
      mcount = 0;
      mhalt  = 1'b0;
      sb.delete();
      return;
    end
    cnt  = mcount;
    ren  = !mhalt && !fl && (cnt < DEPTH || (rdy && cnt != 0));
    push = ren && hit;
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp  = push && cnt == 0;
`endif
    vld  = (cnt != 0) || byp;
    pop  = vld && rdy && !fl;
    chk("imemREN", 32'(imemREN), 32'(ren));
    chk("pc_adv", 32'(pc_adv), 32'(push));
    chk("imemaddr", imemaddr, pc);
    chk("halted", 32'(halted), 32'(mhalt));
    chk("id_valid", 32'(id_valid), 32'(vld));
    if (!vld) begin
      chk("id_instr_empty", id_instr, 32'd0);
      chk("id_pc_plus_empty", id_pc_plus, 32'd0);
    end
    if (fl) begin
      mcount = 0;
      mhalt  = 1'b0;
      sb.delete();
    end else begin
      if (push) begin
        sb.push_back(ent_t'{instr: load, pcp: pc + 32'd4});
        cur_pc = pc + 32'd4;
        if (load[31:26] == HALT) mhalt = 1'b1;
      end
      mcount = cnt + int'(push) - int'(pop);
    end
  endtask

  // Monitor: every accepted handshake must deliver the oldest outstanding entry.
  initial begin
    forever begin : mon
      ent_t e;
      @(negedge CLK);
      #2;
      if (RST === 1'b0 && flush === 1'b0 && id_valid && id_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %h/%h expected nothing queued at %0t",
                   id_instr, id_pc_plus, $time);
        end else begin
          e = sb.pop_front();
          chk("id_instr", id_instr, e.instr);
          chk("id_pc_plus", id_pc_plus, e.pcp);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; fetch_pc = '0; ihit = 1'b0; imemload = '0; flush = 1'b0; id_ready = 1'b0;
    cycle(1, 32'h0, 1, non_halt(), 0, 1);
    cycle(1, 32'h0, 1, non_halt(), 0, 1);

    // Streaming at one instruction per cycle
    cur_pc = 32'h0;
    for (int i = 0; i < 6; i++) cycle(0, cur_pc, 1, non_halt(), 0, 1);

    // Decode stalled: queue fills, then simultaneous push/pop at full
    for (int i = 0; i < 4; i++) cycle(0, cur_pc, 1, non_halt(), 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, cur_pc, 1, non_halt(), 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, cur_pc, 0, 32'h0, 0, 1);

    // icache miss held for 3 cycles at 0x40
    cur_pc = 32'h40;
    for (int i = 0; i < 3; i++) cycle(0, cur_pc, 0, non_halt(), 0, 0);
    cycle(0, cur_pc, 1, non_halt(), 0, 0);
    cycle(0, cur_pc, 0, 32'h0, 0, 1);

    // Flush with two entries queued and a hit in the same cycle
    for (int i = 0; i < 2; i++) cycle(0, cur_pc, 1, non_halt(), 0, 0);
    cycle(0, cur_pc, 1, non_halt(), 1, 0);
    cycle(0, 32'h200, 0, 32'h0, 0, 1);

    // HALT fetched at 0x10, delivered, then fetch stays stopped until a flush
    cur_pc = 32'h10;
    cycle(0, cur_pc, 1, 32'hFC00_0000, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, cur_pc, 1, non_halt(), 0, 1);
    cycle(0, 32'h300, 1, non_halt(), 1, 1);
    cur_pc = 32'h300;
    for (int i = 0; i < 2; i++) cycle(0, cur_pc, 1, non_halt(), 0, 1);

    // PC+4 wraps modulo 2^32
    cycle(0, 32'hFFFF_FFFC, 1, non_halt(), 0, 1);
    cycle(0, cur_pc, 0, 32'h0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, h, f, y;
      logic [31:0] ld;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 11) == 0);
      h  = ($urandom_range(0, 99) < 65);
      y  = ($urandom_range(0, 99) < 70);
      ld = ($urandom_range(0, 9) == 0) ? {HALT, 26'($urandom)} : non_halt();
      cycle(r, cur_pc, h, ld, f, y);
      if (r || f) begin
        cur_pc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
      end
    end

    // Drain and confirm every expected entry was delivered
    for (int i = 0; i < DEPTH + 3; i++) cycle(0, cur_pc, 0, 32'h0, 0, 1);
    @(negedge CLK);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("model_count_drained", 32'(mcount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
